// File: rtl/bram_req_master.sv
// bram_req_master
// Request-side controller for the single-port block-RAM read/write wrapper.
// Takes one command at a time on a valid/ready port, drives the wrapper's
// enable/write-enable/address/data pins, waits for the read-valid strobe
// (bounded by TIMEOUT cycles) and returns a response on a valid/ready port.
// All outputs are registers updated in the same block as the state, so
// they all clear together on the asynchronous reset.
module bram_req_master #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 31,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ena_bram,
  output logic                  wea_bram,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [DATA_WIDTH-1:0] dina,
  input  logic [DATA_WIDTH-1:0] mem_douta,
  input  logic                  mem_valid,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ_REQ  = 3'd2,
    READ_WAIT = 3'd3,
    RESP      = 3'd4
  } state_t;

  // Last counter value still spent waiting; reaching it ends the read with
  // an error, so the 8-bit counter can never wrap.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t                  state_r;
  logic [7:0]              cnt_r;
  logic                    cmd_ready_r;
  logic                    rsp_valid_r;
  logic                    rsp_we_r;
  logic                    rsp_err_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;
  logic                    ena_r;
  logic                    wea_r;
  logic [ADDR_WIDTH-1:0]   addra_r;
  logic [DATA_WIDTH-1:0]   dina_r;
  logic                    busy_r;

  // Transaction FSM with all registered outputs; ena/wea pulses are set on
  // the edge entering WRITE/READ_REQ and cleared on the edge leaving it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_we_r    <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      ena_r       <= 1'b0;
      wea_r       <= 1'b0;
      addra_r     <= {ADDR_WIDTH{1'b0}};
      dina_r      <= {DATA_WIDTH{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // cmd_ready comes up one cycle after reset release and is only
          // honoured once it is visible to the requester.
          if (cmd_valid && cmd_ready_r) begin
            addra_r     <= cmd_addr;
            dina_r      <= cmd_wdata;
            rsp_we_r    <= cmd_we;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            ena_r       <= 1'b1;
            wea_r       <= cmd_we;
            state_r     <= cmd_we ? WRITE : READ_REQ;
          end else begin
            cmd_ready_r <= 1'b1;
            ena_r       <= 1'b0;
            wea_r       <= 1'b0;
            state_r     <= IDLE;
          end
        end
        WRITE: begin
          ena_r       <= 1'b0;
          wea_r       <= 1'b0;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= {DATA_WIDTH{1'b0}};
          rsp_valid_r <= 1'b1;
          state_r     <= RESP;
        end
        READ_REQ: begin
          ena_r   <= 1'b0;
          wea_r   <= 1'b0;
          cnt_r   <= 8'd0;
          state_r <= READ_WAIT;
        end
        READ_WAIT: begin
          cnt_r <= cnt_r + 8'd1;
          if (mem_valid) begin
            // Data wins over a coincident timeout.
            rsp_rdata_r <= mem_douta;
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else if (cnt_r == TMO_LAST) begin
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else begin
            state_r <= READ_WAIT;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          // Unreachable encoding: return quietly to a safe idle.
          ena_r       <= 1'b0;
          wea_r       <= 1'b0;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_we    = rsp_we_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;
  assign ena_bram  = ena_r;
  assign wea_bram  = wea_r;
  assign addra     = addra_r;
  assign dina      = dina_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_bram_req_master.sv
// Directed bench for bram_req_master: a table of transactions run against a
// small BRAM wrapper model with per-transaction read latency (0 = never
// answers), plus hand-written back-pressure, stray-strobe and reset sequences.
module tb_bram_req_master;

  localparam int AW = 15;
  localparam int DW = 31;
  localparam logic [DW-1:0] STRAY_DATA = 31'h2A5A5A5A;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_we;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          ena_bram;
  logic          wea_bram;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [DW-1:0] mem_douta;
  logic          mem_valid;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  bram_req_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .ena_bram(ena_bram), .wea_bram(wea_bram), .addra(addra), .dina(dina),
    .mem_douta(mem_douta), .mem_valid(mem_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wrapper model: writes on ena&wea, reads launch a countdown that raises a
  // one-cycle strobe so that it appears in cycle lat+2 after the command.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_r;
  logic          mv_r;
  int            pend;
  int            lat_v;
  logic          stray_v;

  always @(posedge clk) begin
    mv_r <= 1'b0;
    if (ena_bram && wea_bram) mem[addra[7:0]] <= dina;
    if (ena_bram && !wea_bram) begin
      rd_r <= mem[addra[7:0]];
      pend <= lat_v;
    end else if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) mv_r <= 1'b1;
    end
  end

  assign mem_valid = mv_r | stray_v;
  assign mem_douta = mv_r ? rd_r : (stray_v ? STRAY_DATA : {DW{1'b0}});

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {57'd0, cmd_ready, rsp_valid, rsp_we, rsp_err, ena_bram, wea_bram, busy}, 64'd0);
    chk({tag, "_addra"}, 64'(addra), 64'd0);
    chk({tag, "_dina"}, 64'(dina), 64'd0);
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'd0);
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 (cmd accepted).
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Starts at the negedge of cycle 1; ends at the negedge after the handshake.
  task automatic collect(input string tag, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int exp_cyc, input logic exp_err,
                         input logic [DW-1:0] exp_rdata, input int hold);
    int cyc;
    int bad;
    chk({tag, "_c1_ena"}, 64'(ena_bram), 64'd1);
    chk({tag, "_c1_wea"}, 64'(wea_bram), 64'(we));
    chk({tag, "_c1_addra"}, 64'(addra), 64'(addr));
    chk({tag, "_c1_dina"}, 64'(dina), 64'(wdata));
    chk({tag, "_c1_busy_rdy"}, {62'd0, busy, cmd_ready}, 64'd2);
    cyc = 1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) break;
      if (ena_bram || wea_bram || (addra !== addr) || cmd_ready) bad++;
    end
    chk({tag, "_wait_quiet"}, 64'(bad), 64'd0);
    chk({tag, "_rsp_cycle"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_rsp_we"}, 64'(rsp_we), 64'(we));
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(exp_err));
    chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      stray_v = (i == 3);
      @(negedge clk);
      if (!rsp_valid || cmd_ready || (rsp_we !== we) || (rsp_err !== exp_err) ||
          (rsp_rdata !== exp_rdata) || ena_bram) bad++;
    end
    stray_v = 1'b0;
    if (hold > 0) chk({tag, "_hold_stable"}, 64'(bad), 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_post_idle"}, {61'd0, cmd_ready, rsp_valid, busy}, 64'd4);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
    int            exp_cyc;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int bad;
    vecs[0] = '{1'b1, 15'h0010, 31'h12345678, 0,  2,  1'b0, 31'h0};
    vecs[1] = '{1'b0, 15'h0010, 31'h00000000, 3,  6,  1'b0, 31'h12345678};
    vecs[2] = '{1'b1, 15'h0020, 31'h0ABCDEF0, 0,  2,  1'b0, 31'h0};
    vecs[3] = '{1'b0, 15'h0020, 31'h00000011, 2,  5,  1'b0, 31'h0ABCDEF0};
    vecs[4] = '{1'b0, 15'h0010, 31'h00000000, 0,  17, 1'b1, 31'h0};
    vecs[5] = '{1'b0, 15'h0020, 31'h00000000, 13, 16, 1'b0, 31'h0ABCDEF0};
    vecs[6] = '{1'b0, 15'h0010, 31'h00000000, 14, 17, 1'b0, 31'h12345678};
    vecs[7] = '{1'b0, 15'h0020, 31'h00000000, 15, 17, 1'b1, 31'h0};
    vecs[8] = '{1'b1, 15'h7FFF, 31'h7FFFFFFF, 0,  2,  1'b0, 31'h0};
    vecs[9] = '{1'b0, 15'h7FFF, 31'h00000000, 3,  6,  1'b0, 31'h7FFFFFFF};

    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    stray_v   = 1'b0;
    lat_v     = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;

    for (int v = 0; v < 10; v++) begin
      lat_v = vecs[v].lat;
      issue(vecs[v].we, vecs[v].addr, vecs[v].wdata);
      collect($sformatf("vec%0d", v), vecs[v].we, vecs[v].addr, vecs[v].wdata,
              vecs[v].exp_cyc, vecs[v].exp_err, vecs[v].exp_rdata, 0);
    end

    // Stray strobe while idle: nothing moves, last read data is retained.
    stray_v = 1'b1;
    @(negedge clk);
    stray_v = 1'b0;
    @(negedge clk);
    chk("stray_idle_ctrl", {61'd0, cmd_ready, rsp_valid, busy}, 64'd4);
    chk("stray_idle_rdata", 64'(rsp_rdata), 64'(31'h7FFFFFFF));

    // Back-pressure on a write with the next read already waiting.
    lat_v = 0;
    issue(1'b1, 15'h0030, 31'h01234567);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 15'h0030;
    cmd_wdata = 31'h00000000;
    lat_v     = 3;
    collect("bp_wr", 1'b1, 15'h0030, 31'h01234567, 2, 1'b0, 31'h0, 10);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    collect("bp_rd", 1'b0, 15'h0030, 31'h00000000, 6, 1'b0, 31'h01234567, 0);

    // Reset in READ_WAIT: outputs clear at once and no response follows.
    lat_v = 0;
    issue(1'b0, 15'h0010, 31'h00000000);
    repeat (3) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rsp_valid || ena_bram || busy) bad++;
    end
    chk("after_reset_quiet", 64'(bad), 64'd0);
    lat_v = 3;
    issue(1'b0, 15'h0010, 31'h00000000);
    collect("after_reset_rd", 1'b0, 15'h0010, 31'h00000000, 6, 1'b0, 31'h12345678, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bram_req_master.md
# bram_req_master

Request-side controller for the team's single-port block-RAM read/write wrapper. It accepts one command at a time on a valid/ready command port and drives the wrapper's enable, write-enable, address and data pins with the required pulse and hold discipline. It waits for the wrapper's read-valid strobe, then returns write acknowledgements, read data or a timeout error on a valid/ready response port. It sits between a processor-side agent or DMA sequencer and the BRAM wrapper.

## Interface
- ADDR_WIDTH, 15, address width; must match the wrapper.
- DATA_WIDTH, 31, data width; must match the wrapper.
- TIMEOUT, 15, maximum READ_WAIT cycles without mem_valid before an error response; legal range 1..255.
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low; clears all state.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  command address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_we  out  1  echo of cmd_we for this response.
- rsp_err  out  1  read timed out.
- rsp_rdata  out  DATA_WIDTH  captured read data; 0 for writes and errors.
- ena_bram  out  1  to wrapper enable.
- wea_bram  out  1  to wrapper write enable.
- addra  out  ADDR_WIDTH  to wrapper address.
- dina  out  DATA_WIDTH  to wrapper write data.
- mem_douta  in  DATA_WIDTH  from wrapper read data; non-zero only while mem_valid is high.
- mem_valid  in  1  from wrapper; one-cycle read-data strobe.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WRITE, READ_REQ, READ_WAIT, RESP.
- All outputs are registered or decoded from state. Every output resets to 0, and the state resets to IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch cmd_addr into addra, cmd_wdata into dina, and cmd_we into rsp_we.
  - Next state is WRITE if cmd_we=1, otherwise READ_REQ.
- WRITE:
  - ena_bram=1 and wea_bram=1 for exactly this one cycle.
  - Next state is RESP, with rsp_err=0 and rsp_rdata=0.
- READ_REQ:
  - ena_bram=1 and wea_bram=0 for exactly one cycle; this single pulse starts one wrapper read.
  - Clear the timeout counter. Next state is READ_WAIT.
- READ_WAIT:
  - ena_bram=0 and wea_bram=0; addra is held unchanged.
  - The counter increments each cycle.
  - If mem_valid=1, capture mem_douta into rsp_rdata, set rsp_err=0, and go to RESP.
  - Else, if the counter equals TIMEOUT-1, set rsp_rdata=0, set rsp_err=1, and go to RESP.
  - If mem_valid arrives in the same cycle as the timeout, mem_valid wins (data is captured, no error).
- RESP:
  - rsp_valid=1. rsp_we, rsp_err and rsp_rdata are stable until the handshake.
  - On rsp_ready=1, go to IDLE.
- addra and dina hold their last value until the next command is accepted and are never forced to 0 between commands.
- mem_valid is ignored in every state except READ_WAIT; no capture and no state change result.
- Only one transaction is outstanding at a time; no pipelining.
- A reset mid-transaction abandons it: ena_bram and wea_bram drop immediately (asynchronously), and no response is produced.
- The timeout counter is 8 bits and never wraps, because it leaves READ_WAIT at TIMEOUT-1.

## Timing
- Command accepted at edge 0 (cmd_valid and cmd_ready both high).
- Write: ena_bram/wea_bram high in cycle 1; rsp_valid high from cycle 2. Minimum command-to-command spacing is 3 cycles.
- Read with a wrapper of read latency L (L>=2): ena_bram pulse in cycle 1; mem_valid in cycle 1+L+1; rsp_valid the following cycle.
  - For L=3: ena in cycle 1, mem_valid in cycle 5, rsp_valid in cycle 6.
- Timeout read: rsp_valid at cycle 2+TIMEOUT with rsp_err=1.
- rsp_valid, once high, stays high until the rsp_ready handshake. cmd_ready is low from the accept cycle until the cycle after that handshake.

## Test plan
- Write: reset, then cmd write addr=0x0010 data=0x12345678 -> ena_bram=wea_bram=1 for one cycle with addra=0x0010, dina=0x12345678; rsp_valid next cycle with rsp_we=1, rsp_err=0, rsp_rdata=0.
- Read-back: same address through a latency-3 wrapper model -> single ena_bram pulse in cycle 1, addra held through READ_WAIT; rsp_valid in cycle 6 with rsp_rdata=0x12345678, rsp_err=0.
- Timeout: read to a model that never asserts mem_valid, TIMEOUT=15 -> rsp_valid at cycle 17 with rsp_err=1, rsp_rdata=0.
- Back-pressure: rsp_ready held low for 10 cycles with cmd_valid held high -> rsp_valid and data stable, cmd_ready=0 throughout; the next command is accepted the cycle after rsp_ready rises.
- Stray strobe: mem_valid pulsed while in IDLE and RESP -> no state change, rsp_rdata unchanged.
- Reset: reset asserted during READ_WAIT -> all outputs 0 at once, no response after release; a new read then completes normally.
